// File: rtl/truth_table_capture_pkg.sv
// Shared definitions for the truth-table capture block: FSM encoding,
// sweep geometry and the saturating mismatch increment.
package truth_table_capture_pkg;

    localparam int VEC_COUNT = 16;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 8;
    localparam int MM_W      = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);
    localparam logic [MM_W-1:0]  MM_MAX   = MM_W'(VEC_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    // Mismatch counter never exceeds the number of vectors.
    function automatic logic [MM_W-1:0] sat_inc(input logic [MM_W-1:0] v);
        return (v >= MM_MAX) ? MM_MAX : v + MM_W'(1);
    endfunction

endpackage

// File: rtl/truth_table_capture_settle_counter.sv
// Loadable down-counter with a zero flag; times the settle window.
module truth_table_capture_settle_counter
    import truth_table_capture_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all 16 input vectors of a 4-input function, captures its output
// per vector and compares the captured table against a golden table.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; stimulus holds last vector
// ST_DRIVE  | register current index onto the stimulus rails
// ST_SETTLE | wait SETTLE_CYCLES-1 cycles for the function to settle
// ST_SAMPLE | capture f_in into table_out[index], count mismatches
// ST_FINISH | pulse done, publish pass, return to idle
module truth_table_capture
    import truth_table_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [VEC_COUNT-1:0] expected,
    input  logic                f_in,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic                d,
    output logic                not_a,
    output logic                not_b,
    output logic                not_c,
    output logic                not_d,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [VEC_COUNT-1:0] table_out,
    output logic [MM_W-1:0]     mismatch_count
);

    // Counter is loaded on leaving DRIVE; SETTLE then lasts load+1 cycles.
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES >= 2) ? CNT_W'(SETTLE_CYCLES - 2) : '0;
    localparam bit SKIP_SETTLE = (SETTLE_CYCLES <= 1);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [VEC_COUNT-1:0]   exp_q;
    logic                   settle_zero;

    truth_table_capture_settle_counter #(
        .W (CNT_W)
    ) u_settle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_DRIVE),
        .dec      (state == ST_SETTLE),
        .load_val (SETTLE_LOAD),
        .zero     (settle_zero)
    );

    // Complement rails follow the registered true rails directly.
    assign not_a = ~a;
    assign not_b = ~b;
    assign not_c = ~c;
    assign not_d = ~d;

    // Sweep sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            exp_q          <= '0;
            {a, b, c, d}   <= 4'b0000;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            table_out      <= '0;
            mismatch_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q          <= expected;
                        table_out      <= '0;
                        mismatch_count <= '0;
                        pass           <= 1'b0;
                        idx            <= '0;
                        busy           <= 1'b1;
                        state          <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    {a, b, c, d} <= idx;
                    state        <= SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    table_out[idx] <= f_in;
                    if (f_in != exp_q[idx]) begin
                        mismatch_count <= sat_inc(mismatch_count);
                    end
                    if (idx == LAST_IDX) begin
                        state <= ST_FINISH;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ST_DRIVE;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    pass  <= (mismatch_count == '0);
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture with a 4-input function model.
module tb_truth_table_capture;

    localparam int SC          = 4;
    localparam int SWEEP_EDGES = 16 * (SC + 1);

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic        a, b, c, d;
    logic        not_a, not_b, not_c, not_d;
    logic        busy, done, pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_count;

    logic [15:0] model_tbl;
    bit          tie_one;
    bit          track;
    int          m;
    int          total;
    int          bad;

    truth_table_capture #(
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .expected       (expected),
        .f_in           (f_in),
        .a              (a),
        .b              (b),
        .c              (c),
        .d              (d),
        .not_a          (not_a),
        .not_b          (not_b),
        .not_c          (not_c),
        .not_d          (not_d),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .table_out      (table_out),
        .mismatch_count (mismatch_count)
    );

    // f = (a & b) | (c ^ d) -> table 16'hF666
    assign f_in = tie_one ? 1'b1 : model_tbl[{a, b, c, d}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Rails every cycle; vector order and done timing while a sweep is tracked.
    always @(negedge clk) begin
        chk("rails", {28'd0, not_a, not_b, not_c, not_d}, {28'd0, ~a, ~b, ~c, ~d});
        if (track) begin
            if (m >= 1 && m <= SWEEP_EDGES)
                chk("vec_seq", {28'd0, a, b, c, d}, (m - 1) / (SC + 1));
            if (m >= 1 && m <= SWEEP_EDGES + 2)
                chk("done_pulse", {31'd0, done}, {31'd0, m == SWEEP_EDGES + 1});
            m++;
        end
    end

    task automatic check_reset();
        chk("rst_abcd", {28'd0, a, b, c, d}, 32'h0);
        chk("rst_nabcd", {28'd0, not_a, not_b, not_c, not_d}, 32'hF);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        chk("rst_pass", {31'd0, pass}, 32'h0);
        chk("rst_table", {16'd0, table_out}, 32'h0);
        chk("rst_mm", {27'd0, mismatch_count}, 32'h0);
    endtask

    task automatic run_sweep(input logic [15:0] tbl, input bit tie, input logic [15:0] exp_tbl,
                             input logic [15:0] want_table, input logic [4:0] want_mm,
                             input bit want_pass, input int poke_cyc);
        int cyc;
        bit got_done;
        model_tbl = tbl;
        tie_one   = tie;
        expected  = exp_tbl;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m     = 0;
        track = 1'b1;
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke_cyc);
            if (cyc == 1) begin
                chk("clr_table", {16'd0, table_out}, 32'h0);
                chk("clr_mm", {27'd0, mismatch_count}, 32'h0);
                chk("clr_pass", {31'd0, pass}, 32'h0);
                chk("busy_run", {31'd0, busy}, 32'h1);
            end
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, got_done}, 32'h1);
        chk("sweep_len", cyc - 1, SWEEP_EDGES + 1);
        chk("pass", {31'd0, pass}, {31'd0, want_pass});
        chk("mm_count", {27'd0, mismatch_count}, {27'd0, want_mm});
        chk("table", {16'd0, table_out}, {16'd0, want_table});
        chk("busy_done", {31'd0, busy}, 32'h0);
        @(negedge clk);
        track = 1'b0;
        chk("done_1cyc", {31'd0, done}, 32'h0);
        chk("idle_after", {31'd0, busy}, 32'h0);
        chk("pass_hold", {31'd0, pass}, {31'd0, want_pass});
        chk("hold_vec", {28'd0, a, b, c, d}, 32'hF);
    endtask

    task automatic abort_sweep();
        int cyc;
        int done_cnt;
        model_tbl = 16'hF666;
        tie_one   = 1'b0;
        expected  = 16'hF666;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m     = 0;
        track = 1'b1;
        cyc   = 0;
        while (cyc < 39) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 10);
        end
        chk("vec7", {28'd0, a, b, c, d}, 32'h7);
        rst_n = 1'b0;
        track = 1'b0;
        @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_prio_busy", {31'd0, busy}, 32'h0);
        @(negedge clk);
        start    = 1'b0;
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("no_done_after_abort", done_cnt, 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        track     = 1'b0;
        m         = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        expected  = 16'h0000;
        model_tbl = 16'h0000;
        tie_one   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(16'hF666, 1'b0, 16'hF666, 16'hF666, 5'd0, 1'b1, 10);
        run_sweep(16'hF666, 1'b0, 16'h7667, 16'hF666, 5'd2, 1'b0, 0);
        run_sweep(16'h0000, 1'b1, 16'h0000, 16'hFFFF, 5'd16, 1'b0, 81);
        abort_sweep();
        run_sweep(16'hF666, 1'b0, 16'hF666, 16'hF666, 5'd0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 SETTLE_CYCLES, default 4, number of clock cycles each input vector is held before the function output is sampled; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a 16-vector sweep; honoured only in IDLE.
REQ-005 expected  input  16  golden truth table; bit i is the required function value for vector i; sampled at start acceptance.
REQ-006 f_in  input  1  output of the 4-input function under test.
REQ-007 a, b, c, d  output  1 each  true-rail stimulus to the function under test.
REQ-008 not_a, not_b, not_c, not_d  output  1 each  complement-rail stimulus to the function under test.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 pass  output  1  captured table equals expected; valid from done until the next accepted start.
REQ-012 table_out  output  16  captured truth table; bit i = f_in sampled for vector i.
REQ-013 mismatch_count  output  5  number of bit positions where table_out differs from expected (0..16).

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, FINISH.
REQ-015 IDLE -> DRIVE on start=1; the cycle start is accepted, the block latches expected, clears table_out, mismatch_count and pass, and sets vector index to 0.
REQ-016 DRIVE (1 cycle) SHALL register {a,b,c,d} = index[3:0] (a = MSB), then go to SETTLE.
REQ-017 SETTLE SHALL count SETTLE_CYCLES-1 cycles, then go to SAMPLE; vector therefore stable SETTLE_CYCLES cycles before sampling.
REQ-018 SAMPLE (1 cycle) SHALL write f_in into table_out[index] and increment mismatch_count when f_in differs from expected[index].
REQ-019 From SAMPLE: index < 15 -> increment index, go to DRIVE; index = 15 -> FINISH.
REQ-020 FINISH (1 cycle) SHALL assert done, set pass = (mismatch_count = 0), then return to IDLE.
REQ-021 Complement rails SHALL be the exact inverse of the true rails in every cycle, including reset and IDLE.
REQ-022 Stimulus outputs SHALL hold their last vector in IDLE after a completed sweep.
REQ-023 busy SHALL be 1 in DRIVE, SETTLE, SAMPLE, FINISH; 0 in IDLE.
REQ-024 start while busy SHALL be ignored; no restart, no state change.
REQ-025 start in the same cycle as FINISH SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-026 Sweep length SHALL be exactly 16 x (SETTLE_CYCLES + 1) + 1 cycles from start acceptance to done.
REQ-027 Index SHALL be 4 bits and count 0..15 without wrapping past 15; mismatch_count SHALL saturate at its natural maximum 16.

Reset
REQ-028 On rst_n=0 at a clock edge: state IDLE, index 0, a=b=c=d=0, not_a..not_d=1, busy=0, done=0, pass=0, table_out=0, mismatch_count=0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; all outputs take reset values on the next edge.
REQ-030 rst_n=0 SHALL take priority over start in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the vector count constant (16) and the index width constant (4).
REQ-032 One sub-module, settle_counter (loadable down-counter with zero flag), is the natural split; all other logic SHALL reside in truth_table_capture.

Verification
REQ-033 Reset then idle: rst_n low 2 cycles -> all outputs at reset values, not_a..not_d=1, busy=0.
REQ-034 f_in driven by a model of a 4-input function, expected = that table, SETTLE_CYCLES=4 -> done after 81 cycles, pass=1, mismatch_count=0, table_out=expected.
REQ-035 Same model, expected with bits 0 and 15 flipped -> pass=0, mismatch_count=2, table_out = model table.
REQ-036 f_in tied 1, expected=16'h0000 -> mismatch_count=16, table_out=16'hFFFF, pass=0.
REQ-037 Second start pulse mid-sweep, then rst_n low during vector 7 -> second start ignored; no done pulse; outputs at reset values next cycle; a fresh start completes normally.
REQ-038 Every cycle of all runs: each complement rail equals the inverse of its true rail; vector sequence observed is 0,1,...,15 in order.
